mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequential scan controller paired with the 4:1 mux `m41`: it drives the mux select lines `s1`/`s0` through channels a, b, c, d in order. After a programmable settle time per channel it samples the mux output `out` and assembles a 4-bit frame, one bit per channel. It converts the combinational mux into a clocked, handshaked channel-sampling stage for downstream logic.

## Interface
Parameters:
- `SETTLE`, default 4: cycles each channel is held selected before sampling; legal range 1..256.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a scan; honoured only in IDLE.
- `cont`, input, 1: continuous mode; sampled at each frame end.
- `abort`, input, 1: synchronous abort of the current scan.
- `mux_out`, input, 1: mux `out`.
- `s0`, output, 1: select LSB, to mux `s0`.
- `s1`, output, 1: select MSB, to mux `s1`.
- `frame`, output, 4: last completed frame; bit0=a (00), bit1=b (01), bit2=c (10), bit3=d (11), indexed by {s1,s0}.
- `frame_valid`, output, 1: one-cycle pulse, `frame` just updated.
- `busy`, output, 1: scan in progress.
- `frame_cnt`, output, 8: completed frames, wraps 255->0.

## Operation
- States: IDLE, SCAN.
- Reset: IDLE, `s1`/`s0`=00, `frame`=0, `frame_valid`=0, `busy`=0, `frame_cnt`=0, channel index=0, slot counter=0.
- IDLE to SCAN: on `start`=1 and `abort`=0. Channel index=0 and slot counter=0.
- SCAN: `{s1,s0}` equals the channel index. The slot counter counts 0..SETTLE-1.
- At count SETTLE-1:
  - `mux_out` is captured into capture bit [index].
  - The counter clears and the index increments.
- Frame end, on the index-3 capture edge:
  - `frame` <= {mux_out, cap[2:0]}.
  - `frame_valid` <= 1.
  - `frame_cnt` increments.
  - The index wraps to 0.
- After frame end:
  - If `cont`=1, stay in SCAN with no idle gap.
  - Otherwise go to IDLE.
- `abort`=1 in SCAN:
  - Next edge is IDLE, index and counter = 0.
  - No `frame_valid`; `frame` and `frame_cnt` unchanged.
  - Partial captures are discarded.
- `abort` with `start` in the same IDLE cycle: `abort` wins, stay in IDLE.
- `abort` on the frame-end edge: `abort` wins, no frame is published.
- `start` while in SCAN: ignored.
- Changes to `cont` mid-frame: no effect until frame end.
- Reset asserted mid-scan: immediately returns all outputs to reset values; no partial frame survives.
- In IDLE, `{s1,s0}`=00.

## Timing
- `start` is sampled at edge E0. From E0: `busy`=1 and `{s1,s0}`=00.
- Channel k is selected from E0+k·SETTLE and sampled at edge E0+(k+1)·SETTLE.
- Frame latency:
  - `frame` and `frame_valid` update at E0+4·SETTLE.
  - `frame_valid` is high for exactly that one following cycle.
- In single mode, `busy` falls at the same edge as frame end.
- In continuous mode, frames repeat every 4·SETTLE cycles and `frame_valid` pulses once per frame.
- With SETTLE=1, the select changes every cycle. The external mux output must settle within one cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Slot counter width is max(1, $clog2(SETTLE)).

## Structure
- Package `mux_scan_pkg`:
  - state enum {IDLE, SCAN}
  - `NUM_CH`=4
  - `CH_A..CH_D` select constants 2'b00..2'b11
- Sub-module `mux_scan_timer`: slot counter with parameter `SETTLE`, inputs `clr`/`en`, output `slot_done`.
- The top contains the FSM, channel index, capture register, `frame` register and `frame_cnt`.
- The bench instantiates the real `m41`, with `s0`/`s1` wired back to it.

## Test plan
- **Single scan:** SETTLE=4; a=1, b=0, c=1, d=1 static; `start` pulse at E0 -> `frame`=4'b1101 at E0+16, one `frame_valid` pulse, `frame_cnt`=1, `busy` low after E0+16.
- **Continuous:** SETTLE=2, `cont`=1, d toggled between frames -> pulses every 8 cycles, `frame` alternates 4'b1101/4'b0101; dropping `cont` mid-frame finishes that frame and then goes IDLE.
- **Abort:** abort at E0+9, during channel c -> IDLE at E0+10, `{s1,s0}`=00, no pulse, `frame` keeps its prior value, `frame_cnt` unchanged; `start`+`abort` together -> stays IDLE.
- **Reset mid-scan:** drop `rst_n` at E0+6 without a clock edge -> all outputs zero immediately; after release, a new `start` gives a correct frame.
- **SETTLE=1:** a..d=0,1,1,0 -> `{s1,s0}` steps 00,01,10,11 on consecutive cycles, `frame`=4'b0110 at E0+4.
- **Counter wrap:** 256 continuous frames -> `frame_cnt` goes 255->0 and `frame_valid` still pulses on the wrap frame.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan controller slice.
// Select constants follow the {s1,s0} encoding of the external 4:1 mux.
package mux_scan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int unsigned NUM_CH = 32'd4;

  localparam logic [1:0] CH_A = 2'b00;
  localparam logic [1:0] CH_B = 2'b01;
  localparam logic [1:0] CH_C = 2'b10;
  localparam logic [1:0] CH_D = 2'b11;

  // A settle time of 1 still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned settle);
    int unsigned w;
    if (settle > 32'd2) begin
      w = $clog2(settle);
    end else begin
      w = 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Handshake/data bundle between the scan controller and its user.
// The master drives the request side, the slave (controller) drives the results.
interface mux_scan_ctrl_if;

  logic       start;
  logic       cont;
  logic       abort;
  logic       mux_out;
  logic       s0;
  logic       s1;
  logic [3:0] frame;
  logic       frame_valid;
  logic       busy;
  logic [7:0] frame_cnt;

  modport master (
    output start,
    output cont,
    output abort,
    output mux_out,
    input  s0,
    input  s1,
    input  frame,
    input  frame_valid,
    input  busy,
    input  frame_cnt
  );

  modport slave (
    input  start,
    input  cont,
    input  abort,
    input  mux_out,
    output s0,
    output s1,
    output frame,
    output frame_valid,
    output busy,
    output frame_cnt
  );

endinterface

// File: rtl/m41.sv
// Combinational 4:1 mux, select {s1,s0}: 00->a, 01->b, 10->c, 11->d.
module m41 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic s0,
  input  logic s1,
  output logic out
);

  assign out = s1 ? (s0 ? d : c) : (s0 ? b : a);

endmodule

// File: rtl/mux_scan_timer.sv
// Per-channel settle counter: counts 0..SETTLE-1 while enabled and
// flags the last slot so the controller can sample on that edge.
module mux_scan_timer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 32'd4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic slot_done
);

  localparam int unsigned     CW   = cnt_width(SETTLE);
  localparam logic [CW-1:0]   LAST = CW'(SETTLE - 32'd1);
  localparam logic [CW-1:0]   ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   ONE  = CW'(32'd1);

  logic [CW-1:0] r_cnt;

  assign slot_done = en & (r_cnt == LAST);

  // Slot counter; clear has priority so an abort restarts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= ZERO;
    end else if (clr) begin
      r_cnt <= ZERO;
    end else if (en) begin
      if (r_cnt == LAST) begin
        r_cnt <= ZERO;
      end else begin
        r_cnt <= r_cnt + ONE;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller: steps the external mux through a..d, samples each
// channel after its settle time and publishes a 4-bit frame.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 32'd4
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_ctrl_if.slave bus
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [1:0] r_idx;
  logic [3:0] r_cap;
  logic [3:0] r_frame;
  logic       r_frame_valid;
  logic [7:0] r_frame_cnt;

  logic       w_en;
  logic       w_clr;
  logic       w_slot_done;
  logic       w_capture;
  logic       w_frame_end;

  assign w_en = (r_state == SCAN);

  mux_scan_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_clr),
    .en        (w_en),
    .slot_done (w_slot_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle control; abort beats start and frame end.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b1;
    w_capture   = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          w_state_nxt = SCAN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_clr       = 1'b0;
          w_capture   = w_slot_done;
          w_frame_end = w_slot_done && (r_idx == CH_D);
          if (w_frame_end && !bus.cont) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = SCAN;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Channel index and partial capture; both discarded outside an active scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= CH_A;
      r_cap <= 4'b0000;
    end else if ((r_state != SCAN) || bus.abort) begin
      r_idx <= CH_A;
      r_cap <= 4'b0000;
    end else if (w_capture) begin
      r_idx        <= r_idx + 2'd1;
      r_cap[r_idx] <= bus.mux_out;
    end else begin
      r_idx <= r_idx;
      r_cap <= r_cap;
    end
  end

  // Published frame; the channel d bit comes straight from the mux on the last edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame       <= 4'b0000;
      r_frame_valid <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else if (w_frame_end) begin
      r_frame       <= {bus.mux_out, r_cap[2:0]};
      r_frame_valid <= 1'b1;
      r_frame_cnt   <= r_frame_cnt + 8'd1;
    end else begin
      r_frame       <= r_frame;
      r_frame_valid <= 1'b0;
      r_frame_cnt   <= r_frame_cnt;
    end
  end

  assign bus.s1          = r_idx[1];
  assign bus.s0          = r_idx[0];
  assign bus.busy        = (r_state == SCAN);
  assign bus.frame       = r_frame;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (SETTLE=1,2,4) with real m41 muxes,
// shared random stimulus, checked each cycle against a timing-rule model.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       t_start;
  logic       t_cont;
  logic       t_abort;
  logic [3:0] t_ch;

  always #5 clk = ~clk;

  logic [15:0] obs [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned ST = (g == 0) ? 32'd1 : ((g == 1) ? 32'd2 : 32'd4);
    mux_scan_ctrl_if bus ();
    logic w_mo;
    assign bus.start   = t_start;
    assign bus.cont    = t_cont;
    assign bus.abort   = t_abort;
    assign bus.mux_out = w_mo;
    m41 u_mux (
      .a   (t_ch[0]),
      .b   (t_ch[1]),
      .c   (t_ch[2]),
      .d   (t_ch[3]),
      .s0  (bus.s0),
      .s1  (bus.s1),
      .out (w_mo)
    );
    mux_scan_ctrl #(
      .SETTLE (ST)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign obs[g] = {bus.s1, bus.s0, bus.busy, bus.frame_valid, bus.frame, bus.frame_cnt};
  end

  // Model: elapsed cycles since the start edge determine channel and sample points.
  int         st [3] = '{1, 2, 4};
  bit         m_busy [3];
  int         m_el [3];
  logic [3:0] m_cap [3];
  logic [3:0] m_frame [3];
  logic       m_fv [3];
  logic [7:0] m_cnt [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_vec(input int i);
    logic [1:0] sel;
    sel = m_busy[i] ? 2'(m_el[i] / st[i]) : 2'b00;
    return {sel, m_busy[i], m_fv[i], m_frame[i], m_cnt[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0; m_el[i] = 0; m_cap[i] = 4'h0;
      m_frame[i] = 4'h0; m_fv[i] = 1'b0; m_cnt[i] = 8'd0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int nxt;
      logic [1:0] ch;
      m_fv[i] = 1'b0;
      if (!m_busy[i]) begin
        if (t_start && !t_abort) begin
          m_busy[i] = 1'b1;
          m_el[i]   = 0;
        end
      end else if (t_abort) begin
        m_busy[i] = 1'b0;
        m_el[i]   = 0;
      end else begin
        ch  = 2'(m_el[i] / st[i]);
        nxt = m_el[i] + 1;
        if (nxt % st[i] == 0) m_cap[i][ch] = t_ch[ch];
        if (nxt == 4 * st[i]) begin
          m_frame[i] = m_cap[i];
          m_fv[i]    = 1'b1;
          m_cnt[i]   = m_cnt[i] + 8'd1;
          m_el[i]    = 0;
          if (!t_cont) m_busy[i] = 1'b0;
        end else begin
          m_el[i] = nxt;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_val($sformatf("%s/S%0d", tag, st[i]), obs[i], exp_vec(i));
  endtask

  // Reset dropped between edges must clear every output before the next edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) check_val($sformatf("%s/S%0d", tag, st[i]), obs[i], 16'h0000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; t_start = 1'b0; t_cont = 1'b0; t_abort = 1'b0; t_ch = 4'h0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_val($sformatf("reset/S%0d", st[i]), obs[i], 16'h0000);
    rst_n = 1'b1;

    // Single scan, a=1 b=0 c=1 d=1.
    t_ch = 4'b1101;
    t_start = 1'b1; step("single");
    t_start = 1'b0;
    repeat (20) step("single");
    check_val("single_frame_S4", {12'h000, obs[2][11:8]}, 16'h000d);
    check_val("single_cnt_S4", {8'h00, obs[2][7:0]}, 16'h0001);

    // Abort mid-frame, then start together with abort.
    t_ch = 4'b0110;
    t_start = 1'b1; step("abort");
    t_start = 1'b0;
    repeat (8) step("abort");
    t_abort = 1'b1; step("abort");
    t_abort = 1'b0; step("abort");
    check_val("abort_idle_S4", {13'h0000, obs[2][15:13]}, 16'h0000);
    t_start = 1'b1; t_abort = 1'b1; step("start_abort");
    t_start = 1'b0; t_abort = 1'b0; step("start_abort");

    // Reset mid-scan, then a clean frame.
    t_start = 1'b1; step("rst_mid");
    t_start = 1'b0;
    repeat (5) step("rst_mid");
    async_reset("rst_async");
    t_ch = 4'b1011;
    t_start = 1'b1; step("after_rst");
    t_start = 1'b0;
    repeat (20) step("after_rst");

    // Continuous scan with cont dropped mid-frame.
    t_cont = 1'b1; t_start = 1'b1; step("cont");
    t_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k % 8 == 0) t_ch[3] = ~t_ch[3];
      step("cont");
    end
    t_cont = 1'b0;
    repeat (20) step("cont_drop");

    // Random traffic with occasional async resets.
    for (int k = 0; k < 3000; k++) begin
      t_start = ($urandom_range(0, 7) == 0);
      t_abort = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) t_cont = ~t_cont;
      if ($urandom_range(0, 3) == 0) t_ch = 4'($urandom);
      if ($urandom_range(0, 499) == 0) async_reset("rst_rand");
      step("rand");
    end

    // Long continuous run so every frame counter wraps.
    t_abort = 1'b0; t_cont = 1'b1; t_start = 1'b1; step("wrap");
    t_start = 1'b0;
    for (int k = 0; k < 4 * 4 * 258; k++) begin
      if ($urandom_range(0, 7) == 0) t_ch = 4'($urandom);
      step("wrap");
    end
    t_cont = 1'b0;
    repeat (40) step("tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
